// File: rtl/ula_scheduler.sv
// ula_scheduler: round-robin front end that shares one ALU among NUM_REQ
// requesters, with a single command outstanding at a time.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   per-requester command handshake (ready one-hot)
//   req_op_i, req_a_i, req_b_i  packed per-requester op code and operands
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_id_o, rsp_result_o,
//   rsp_carry_o, rsp_err_o      response payload
//   alu_op_selector_o,
//   alu_data_a_o, alu_data_b_o  ALU command, non-zero only during ISSUE
//   alu_data_valid_i,
//   alu_data_result_i,
//   alu_data_carryout_i         ALU result
//
// Optional feature: define ULA_SCHED_DIV0_CHECK_EN to answer DIV with b=0
// locally with an error instead of sending it to the ALU.
//
// state | meaning
// IDLE  | waiting for a request; grants one round-robin
// ISSUE | ALU command driven for this single cycle
// WAIT  | waiting for ALU valid or timeout
// RESP  | response held until rsp_ready_i
module ula_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [5*NUM_REQ-1:0]   req_op_i,
  input  logic [16*NUM_REQ-1:0]  req_a_i,
  input  logic [16*NUM_REQ-1:0]  req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [2:0]             rsp_id_o,
  output logic [31:0]            rsp_result_o,
  output logic                   rsp_carry_o,
  output logic                   rsp_err_o,
  output logic [4:0]             alu_op_selector_o,
  output logic [15:0]            alu_data_a_o,
  output logic [15:0]            alu_data_b_o,
  input  logic                   alu_data_valid_i,
  input  logic [31:0]            alu_data_result_i,
  input  logic                   alu_data_carryout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [4:0] OP_UNUSED = 5'd0;
  localparam logic [4:0] OP_DIV    = 5'd4;
  localparam logic [4:0] OP_REV    = 5'd8;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [2:0]  last_grant_q;
  logic [7:0]  cnt_q;
  logic [4:0]  alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic        rsp_valid_q, rsp_carry_q, rsp_err_q;
  logic [2:0]  rsp_id_q;
  logic [31:0] rsp_result_q;

  logic        gnt_found;
  logic [2:0]  gnt_idx;
  logic [4:0]  sel_op;
  logic [15:0] sel_a, sel_b;
  logic        sel_legal, sel_div0;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant_q) + i) % NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    sel_op    = req_op_i[5*int'(gnt_idx) +: 5];
    sel_a     = req_a_i[16*int'(gnt_idx) +: 16];
    sel_b     = req_b_i[16*int'(gnt_idx) +: 16];
    sel_legal = (sel_op != OP_UNUSED) && (sel_op <= OP_REV);
`ifdef ULA_SCHED_DIV0_CHECK_EN
    sel_div0  = (sel_op == OP_DIV) && (sel_b == 16'd0);
`else
    sel_div0  = 1'b0;
`endif
  end

  // The grant is only visible while IDLE; rst_ni gates it so a requester
  // holding valid during reset never sees an accept.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state_q == S_IDLE && gnt_found)
      req_ready_o = NUM_REQ'(1) << gnt_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      cnt_q        <= '0;
      alu_op_q     <= OP_UNUSED;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            last_grant_q <= gnt_idx;
            rsp_id_q     <= gnt_idx;
            if (!sel_legal || sel_div0) begin
              // Answered locally; the ALU never sees the command.
              rsp_valid_q  <= 1'b1;
              rsp_err_q    <= 1'b1;
              rsp_carry_q  <= 1'b0;
              rsp_result_q <= sel_legal ? 32'hFFFF_FFFF : 32'd0;
              state_q      <= S_RESP;
            end else begin
              alu_op_q <= sel_op;
              alu_a_q  <= sel_a;
              alu_b_q  <= sel_b;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          alu_op_q <= OP_UNUSED;
          alu_a_q  <= '0;
          alu_b_q  <= '0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (alu_data_valid_i) begin
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= alu_data_result_i;
            rsp_carry_q  <= alu_data_carryout_i;
            state_q      <= S_RESP;
          end else if (cnt_q == TO_LAST) begin
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_id_o          = rsp_id_q;
  assign rsp_result_o      = rsp_result_q;
  assign rsp_carry_o       = rsp_carry_q;
  assign rsp_err_o         = rsp_err_q;
  assign alu_op_selector_o = alu_op_q;
  assign alu_data_a_o      = alu_a_q;
  assign alu_data_b_o      = alu_b_q;

endmodule

// File: tb/tb_ula_scheduler.sv
module tb_ula_scheduler;
  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i, req_ready_o;
  logic [5*N-1:0]  req_op_i;
  logic [16*N-1:0] req_a_i, req_b_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [2:0]      rsp_id_o;
  logic [31:0]     rsp_result_o;
  logic            rsp_carry_o, rsp_err_o;
  logic [4:0]      alu_op_selector_o;
  logic [15:0]     alu_data_a_o, alu_data_b_o;
  logic            alu_data_valid_i;
  logic [31:0]     alu_data_result_i;
  logic            alu_data_carryout_i;

  int checks = 0;
  int errors = 0;
  int alu_mode = 1;       // 1: fake ALU answers one cycle after ISSUE
  logic alu_stray = 1'b0; // spurious valid while no command is outstanding
  logic [31:0] alu_r;
  logic        alu_c;

  always #5 clk_i = ~clk_i;

  ula_scheduler #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o),
    .rsp_carry_o(rsp_carry_o), .rsp_err_o(rsp_err_o),
    .alu_op_selector_o(alu_op_selector_o),
    .alu_data_a_o(alu_data_a_o), .alu_data_b_o(alu_data_b_o),
    .alu_data_valid_i(alu_data_valid_i),
    .alu_data_result_i(alu_data_result_i),
    .alu_data_carryout_i(alu_data_carryout_i)
  );

  // Fake ALU: result = a + b, carry set for SUB (op 2).
  always begin
    @(posedge clk_i); #1;
    if (alu_mode == 1 && alu_op_selector_o != 5'd0) begin
      alu_r = 32'(alu_data_a_o) + 32'(alu_data_b_o);
      alu_c = (alu_op_selector_o == 5'd2);
      @(posedge clk_i); #1;
      alu_data_valid_i    = 1'b1;
      alu_data_result_i   = alu_r;
      alu_data_carryout_i = alu_c;
      @(posedge clk_i); #1;
      alu_data_valid_i    = 1'b0;
      alu_data_result_i   = '0;
      alu_data_carryout_i = 1'b0;
    end else begin
      alu_data_valid_i = alu_stray;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int k, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op_i[5*k +: 5]  = op;
    req_a_i[16*k +: 16] = a;
    req_b_i[16*k +: 16] = b;
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n;
    bit found;

    rst_ni = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    rsp_ready_i = 1'b0;
    #22 rst_ni = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_id",    32'(rsp_id_o), 32'h0);
    chk("rst_result",    rsp_result_o, 32'h0);
    chk("rst_alu_op",    32'(alu_op_selector_o), 32'h0);
    chk("rst_alu_a",     32'(alu_data_a_o), 32'h0);

    // ADD on requester 0
    step();
    set_req(0, 5'd1, 16'h0003, 16'h0004);
    req_valid_i = 4'b0001;
    settle();
    chk("add_grant", 32'(req_ready_o), 32'h1);
    chk("idle_alu_op", 32'(alu_op_selector_o), 32'h0);
    step();
    req_valid_i = '0;
    settle();
    chk("issue_ready", 32'(req_ready_o), 32'h0);
    chk("issue_op", 32'(alu_op_selector_o), 32'h1);
    chk("issue_a",  32'(alu_data_a_o), 32'h3);
    chk("issue_b",  32'(alu_data_b_o), 32'h4);
    step(); settle();
    chk("wait_alu_op", 32'(alu_op_selector_o), 32'h0);
    step(); settle();
    chk("add_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("add_rsp_id",    32'(rsp_id_o), 32'h0);
    chk("add_result",    rsp_result_o, 32'h7);
    chk("add_err",       32'(rsp_err_o), 32'h0);
    chk("add_carry",     32'(rsp_carry_o), 32'h0);

    // Back-pressure: response must hold, requester 1 must wait
    set_req(1, 5'd2, 16'h000A, 16'h0003);
    req_valid_i = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step(); settle();
      chk("hold_valid",  32'(rsp_valid_o), 32'h1);
      chk("hold_result", rsp_result_o, 32'h7);
      chk("hold_ready",  32'(req_ready_o), 32'h0);
    end
    rsp_ready_i = 1'b1;
    settle();
    chk("handshake_no_grant", 32'(req_ready_o), 32'h0);
    step();
    rsp_ready_i = 1'b0;
    settle();
    chk("post_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rr_next_grant",  32'(req_ready_o), 32'h2);
    step();
    req_valid_i = '0;
    settle();
    chk("sub_op", 32'(alu_op_selector_o), 32'h2);
    chk("sub_a",  32'(alu_data_a_o), 32'hA);
    step(); step(); settle();
    chk("sub_rsp_id", 32'(rsp_id_o), 32'h1);
    chk("sub_result", rsp_result_o, 32'hD);
    chk("sub_carry",  32'(rsp_carry_o), 32'h1);
    rsp_ready_i = 1'b1;
    step();

    // Round-robin from reset with all requesters busy
    rst_ni = 1'b0;
    settle();
    step();
    rst_ni = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 5'd1, 16'(k), 16'h0001);
    req_valid_i = 4'b1111;
    settle();
    for (int g = 0; g < 5; g++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (req_ready_o != '0) found = 1'b1;
        else begin step(); settle(); end
      end
      chk("rr_grant", 32'(req_ready_o), 32'h1 << exp_order[g]);
      step(); settle();
    end
    req_valid_i = '0;
    step(); step();
    chk("rr_last_id",     32'(rsp_id_o), 32'h0);
    chk("rr_last_result", rsp_result_o, 32'h1);
    step();

    // Illegal op on requester 2
    set_req(2, 5'h0F, 16'h0005, 16'h0006);
    req_valid_i = 4'b0100;
    settle();
    chk("ill_grant", 32'(req_ready_o), 32'h4);
    step();
    req_valid_i = '0;
    settle();
    chk("ill_alu_op", 32'(alu_op_selector_o), 32'h0);
    chk("ill_valid",  32'(rsp_valid_o), 32'h1);
    chk("ill_id",     32'(rsp_id_o), 32'h2);
    chk("ill_err",    32'(rsp_err_o), 32'h1);
    chk("ill_result", rsp_result_o, 32'h0);
    step();

    // Timeout: ALU never answers
    alu_mode = 0;
    rsp_ready_i = 1'b0;
    set_req(3, 5'd1, 16'h0001, 16'h0001);
    req_valid_i = 4'b1000;
    settle();
    chk("to_grant", 32'(req_ready_o), 32'h8);
    step();
    req_valid_i = '0;
    settle();
    chk("to_issue_op", 32'(alu_op_selector_o), 32'h1);
    n = 0;
    while (n < 40 && !rsp_valid_o) begin
      step(); settle();
      n++;
    end
    chk("to_wait_cycles", 32'(n - 1), 32'd15);
    chk("to_err",    32'(rsp_err_o), 32'h1);
    chk("to_result", rsp_result_o, 32'h0);
    chk("to_id",     32'(rsp_id_o), 32'h3);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // Reset during WAIT, then a stray ALU valid in IDLE
    set_req(0, 5'd1, 16'h0002, 16'h0002);
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    step(); step();
    rst_ni = 1'b0;
    req_valid_i = 4'b0001;
    settle();
    chk("midrst_ready",  32'(req_ready_o), 32'h0);
    chk("midrst_valid",  32'(rsp_valid_o), 32'h0);
    chk("midrst_alu_op", 32'(alu_op_selector_o), 32'h0);
    chk("midrst_err",    32'(rsp_err_o), 32'h0);
    chk("midrst_result", rsp_result_o, 32'h0);
    step();
    req_valid_i = '0;
    rst_ni = 1'b1;
    alu_stray = 1'b1;
    step(); step(); step(); settle();
    chk("stray_ignored", 32'(rsp_valid_o), 32'h0);
    alu_stray = 1'b0;
    step();

    // DIV by zero on requester 1
    alu_mode = 1;
    set_req(1, 5'd4, 16'h0010, 16'h0000);
    req_valid_i = 4'b0010;
    settle();
    chk("div_grant", 32'(req_ready_o), 32'h2);
    step();
    req_valid_i = '0;
    settle();
`ifdef ULA_SCHED_DIV0_CHECK_EN
    chk("div0_alu_op", 32'(alu_op_selector_o), 32'h0);
    chk("div0_valid",  32'(rsp_valid_o), 32'h1);
    chk("div0_err",    32'(rsp_err_o), 32'h1);
    chk("div0_result", rsp_result_o, 32'hFFFF_FFFF);
`else
    chk("div_alu_op", 32'(alu_op_selector_o), 32'h4);
    chk("div_alu_a",  32'(alu_data_a_o), 32'h10);
    chk("div_alu_b",  32'(alu_data_b_o), 32'h0);
    step(); step(); settle();
    chk("div_valid",  32'(rsp_valid_o), 32'h1);
    chk("div_result", rsp_result_o, 32'h10);
    chk("div_err",    32'(rsp_err_o), 32'h0);
`endif
    rsp_ready_i = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_scheduler.md
ULA_SCHEDULER -- requirements
Module: ula_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for ALU valid (1..255).
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have req_valid  input  NUM_REQ  per-requester command valid.
REQ-006 SHALL have req_ready  output  NUM_REQ  per-requester command accept, one-hot or zero.
REQ-007 SHALL have req_op  input  5*NUM_REQ  per-requester op code, slice k = [5k+4:5k].
REQ-008 SHALL have req_a / req_b  input  16*NUM_REQ each  per-requester operands.
REQ-009 SHALL have rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-010 SHALL have rsp_id  output  3  index of requester owning the response.
REQ-011 SHALL have rsp_result  output  32, rsp_carry  output  1, rsp_err  output  1.
REQ-012 SHALL have alu_op_selector  output  5, alu_data_a / alu_data_b  output  16 each  ALU command.
REQ-013 SHALL have alu_data_valid  input  1, alu_data_result  input  32, alu_data_carryout  input  1  ALU result.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE: if any req_valid, SHALL grant one requester round-robin, assert its req_ready for exactly that cycle, latch op/a/b/id, go to ISSUE.
REQ-016 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-017 Legal op codes SHALL be 1..8 (ADD,SUB,MUL,DIV,AND,OR,XOR,REV); an illegal code SHALL skip ISSUE/WAIT, go to RESP with rsp_err=1, rsp_result=0, rsp_carry=0.
REQ-018 ISSUE: SHALL drive latched op/a/b on ALU port for exactly one cycle, then go to WAIT.
REQ-019 Outside ISSUE, alu_op_selector SHALL be 0 (OP_UNUSED) and alu_data_a/b SHALL be 0.
REQ-020 WAIT: SHALL increment a timeout counter each cycle; on first cycle alu_data_valid=1 SHALL capture result/carry, rsp_err=0, go to RESP.
REQ-021 WAIT: if counter reaches TIMEOUT without valid, SHALL go to RESP with rsp_err=1, rsp_result=0, rsp_carry=0.
REQ-022 RESP: rsp_valid SHALL be 1 with rsp_id/result/carry/err stable until rsp_ready=1; on handshake go to IDLE.
REQ-023 Only one command SHALL be outstanding; req_ready SHALL be 0 in ISSUE, WAIT, RESP.
REQ-024 Requests arriving during busy states SHALL be held by requesters, not dropped or queued internally.
REQ-025 Response-to-next-grant SHALL take at least one IDLE cycle (no grant in the cycle of RESP handshake).
REQ-026 rsp_id SHALL be zero-extended index; unused upper bits 0.

Reset
REQ-027 On rst=0 asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_err=0, alu outputs=0, timeout counter=0, last_grant=NUM_REQ-1.
REQ-028 Reset mid-operation SHALL abandon the outstanding command without a response; ALU results arriving after reset release SHALL be ignored in IDLE.

Configuration
REQ-029 Macro ULA_SCHED_DIV0_CHECK_EN, when defined: op DIV with b=0 SHALL skip ISSUE/WAIT, go to RESP with rsp_err=1, rsp_result=32'hFFFF_FFFF, rsp_carry=0.
REQ-030 Without ULA_SCHED_DIV0_CHECK_EN: DIV with b=0 SHALL be issued to the ALU like any other legal op.

Verification
REQ-031 Single req0 ADD a=16'h0003 b=16'h0004, ALU returns 32'h7 valid next cycle -> rsp_valid, rsp_id=0, rsp_result=32'h7, rsp_err=0.
REQ-032 All four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0; no requester granted twice before all others.
REQ-033 req2 op=5'h0F -> no ALU issue (alu_op_selector stays 0), rsp_id=2, rsp_err=1, rsp_result=0.
REQ-034 ALU never asserts valid, TIMEOUT=15 -> rsp_err=1 exactly 15 WAIT cycles after ISSUE.
REQ-035 rsp_ready held 0 for 10 cycles in RESP -> rsp outputs stable, req_ready stays 0; rst=0 during WAIT -> all outputs 0 immediately, no response.
REQ-036 DIV a=16'h0010 b=0: with ULA_SCHED_DIV0_CHECK_EN -> rsp_err=1, result 32'hFFFF_FFFF, no issue; without -> op 4 issued to ALU.
